// File: rtl/nv_nvdla_sdp_cmux.sv
// SDP source mux: picks the MRDMA or CACC stream per layer, forwards the programmed
// beat count through a 2-entry registered FIFO, and pulses done on the final output beat.
module nv_nvdla_sdp_cmux #(
    parameter int unsigned DW = 512
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          op_load,
    input  logic          reg2dp_flying_mode,
    input  logic [31:0]   reg2dp_beat_num,
    input  logic          reg2dp_perf_dma_en,
    input  logic          sdp_mrdma2cmux_valid,
    output logic          sdp_mrdma2cmux_ready,
    input  logic [DW+1:0] sdp_mrdma2cmux_pd,
    input  logic          cacc2sdp_valid,
    output logic          cacc2sdp_ready,
    input  logic [DW+1:0] cacc2sdp_pd,
    output logic          sdp_cmux2dp_valid,
    input  logic          sdp_cmux2dp_ready,
    output logic [DW+1:0] sdp_cmux2dp_pd,
    output logic          cmux_done,
    output logic [31:0]   dp2reg_cmux_stall
);

    localparam int unsigned PW = DW + 2;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, nxt_state;
    logic            mode_q, nxt_mode;
    logic [CW-1:0]   last_q, nxt_last;
    logic [CW-1:0]   in_cnt_q, nxt_in_cnt;
    logic [CW-1:0]   out_cnt_q, nxt_out_cnt;
    logic            last_hit_q, nxt_last_hit;
    logic [CW-1:0]   stall_q, nxt_stall;
    logic            mrdma_rdy_q, nxt_mrdma_rdy;
    logic            cacc_rdy_q, nxt_cacc_rdy;

    logic [PW-1:0]   fifo_mem [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      fifo_cnt_q, nxt_fifo_cnt;

    logic            in_vld, in_rdy, push, pop, fifo_not_empty;
    logic [PW-1:0]   in_pd;

    assign in_vld         = mode_q ? cacc2sdp_valid : sdp_mrdma2cmux_valid;
    assign in_rdy         = mode_q ? cacc_rdy_q : mrdma_rdy_q;
    assign in_pd          = mode_q ? cacc2sdp_pd : sdp_mrdma2cmux_pd;
    assign push           = in_vld & in_rdy;
    assign fifo_not_empty = (fifo_cnt_q != 2'd0);
    assign pop            = fifo_not_empty & sdp_cmux2dp_ready;

    assign sdp_mrdma2cmux_ready = mrdma_rdy_q;
    assign cacc2sdp_ready       = cacc_rdy_q;
    assign sdp_cmux2dp_valid    = fifo_not_empty;
    assign sdp_cmux2dp_pd       = fifo_mem[rd_ptr_q];
    assign cmux_done            = pop & last_hit_q;
    assign dp2reg_cmux_stall    = stall_q;

    // Next-state and counter logic
    always_comb begin
        nxt_state   = state_q;
        nxt_mode    = mode_q;
        nxt_last    = last_q;
        nxt_in_cnt  = in_cnt_q;
        nxt_out_cnt = out_cnt_q;
        nxt_stall   = stall_q;

        if (fifo_not_empty && !sdp_cmux2dp_ready && reg2dp_perf_dma_en && (stall_q != '1)) begin
            nxt_stall = stall_q + 32'd1;
        end
        if (pop) begin
            nxt_out_cnt = out_cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (op_load) begin
                    nxt_mode    = reg2dp_flying_mode;
                    nxt_last    = reg2dp_beat_num;
                    nxt_in_cnt  = '0;
                    nxt_out_cnt = '0;
                    nxt_stall   = '0;
                    nxt_state   = RUN;
                end
            end
            RUN: begin
                if (push) begin
                    nxt_in_cnt = in_cnt_q + 32'd1;
                    if (in_cnt_q == last_q) begin
                        nxt_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cmux_done) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        nxt_fifo_cnt  = fifo_cnt_q + 2'(push) - 2'(pop);
        nxt_last_hit  = (nxt_out_cnt == nxt_last);
        // Readys are registered from post-cycle occupancy, so no output-ready feedthrough
        nxt_mrdma_rdy = (nxt_state == RUN) && !nxt_mode && (nxt_fifo_cnt != 2'd2);
        nxt_cacc_rdy  = (nxt_state == RUN) &&  nxt_mode && (nxt_fifo_cnt != 2'd2);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            last_q      <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            last_hit_q  <= 1'b0;
            stall_q     <= '0;
            mrdma_rdy_q <= 1'b0;
            cacc_rdy_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state_q     <= nxt_state;
            mode_q      <= nxt_mode;
            last_q      <= nxt_last;
            in_cnt_q    <= nxt_in_cnt;
            out_cnt_q   <= nxt_out_cnt;
            last_hit_q  <= nxt_last_hit;
            stall_q     <= nxt_stall;
            mrdma_rdy_q <= nxt_mrdma_rdy;
            cacc_rdy_q  <= nxt_cacc_rdy;
            fifo_cnt_q  <= nxt_fifo_cnt;
            wr_ptr_q    <= wr_ptr_q ^ push;
            rd_ptr_q    <= rd_ptr_q ^ pop;
            if (push) begin
                fifo_mem[wr_ptr_q] <= in_pd;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_cmux.sv
// Randomized bench for nv_nvdla_sdp_cmux against a beat-queue reference model.
module tb_nv_nvdla_sdp_cmux;

    localparam int unsigned DW = 32;
    localparam int unsigned PW = DW + 2;

    logic          clk;
    logic          rstn;
    logic          op_load;
    logic          flying;
    logic [31:0]   beat_num;
    logic          perf_en;
    logic          m_valid, m_ready;
    logic [PW-1:0] m_pd;
    logic          c_valid, c_ready;
    logic [PW-1:0] c_pd;
    logic          o_valid, o_ready;
    logic [PW-1:0] o_pd;
    logic          done;
    logic [31:0]   stall;

    nv_nvdla_sdp_cmux #(.DW(DW)) dut (
        .nvdla_core_clk       (clk),
        .nvdla_core_rstn      (rstn),
        .op_load              (op_load),
        .reg2dp_flying_mode   (flying),
        .reg2dp_beat_num      (beat_num),
        .reg2dp_perf_dma_en   (perf_en),
        .sdp_mrdma2cmux_valid (m_valid),
        .sdp_mrdma2cmux_ready (m_ready),
        .sdp_mrdma2cmux_pd    (m_pd),
        .cacc2sdp_valid       (c_valid),
        .cacc2sdp_ready       (c_ready),
        .cacc2sdp_pd          (c_pd),
        .sdp_cmux2dp_valid    (o_valid),
        .sdp_cmux2dp_ready    (o_ready),
        .sdp_cmux2dp_pd       (o_pd),
        .cmux_done            (done),
        .dp2reg_cmux_stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference model state: beats of the current layer, accepted-but-not-delivered queue
    logic [PW-1:0] exp_q[$];
    bit            mode;
    bit            active;
    bit            noise;
    bit            use_seq;
    int            n;
    int            sent;
    int            rcvd;
    int            done_cnt;
    int            in_prob;
    int            out_prob;
    int            force_left;
    logic [31:0]   stall_exp;
    bit            src_valid;
    logic [PW-1:0] src_pd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check settled outputs against the model, advance an edge
    task automatic step();
        logic          sel_rdy, oth_rdy, in_hs, out_hs;
        logic [PW-1:0] exp_pd;
        if (active && !src_valid && (sent < n) && ($urandom_range(0, 99) < in_prob)) begin
            src_valid = 1'b1;
            src_pd    = use_seq ? PW'(sent + 1) : PW'({$urandom(), $urandom()});
        end
        if (force_left > 0 && o_valid) begin
            o_ready = 1'b0;
            force_left--;
        end else begin
            o_ready = ($urandom_range(0, 99) < out_prob);
        end
        if (mode) begin
            c_valid = src_valid;
            c_pd    = src_pd;
            m_valid = noise;
            m_pd    = PW'({$urandom(), $urandom()});
        end else begin
            m_valid = src_valid;
            m_pd    = src_pd;
            c_valid = noise;
            c_pd    = PW'({$urandom(), $urandom()});
        end
        #1;
        sel_rdy = mode ? c_ready : m_ready;
        oth_rdy = mode ? m_ready : c_ready;
        check("out_valid", 64'(o_valid), 64'(exp_q.size() != 0));
        check("in_ready", 64'(sel_rdy), 64'(active && (sent < n) && (exp_q.size() < 2)));
        check("other_ready", 64'(oth_rdy), 64'd0);
        in_hs  = src_valid & sel_rdy;
        out_hs = o_valid & o_ready;
        if (o_valid && !o_ready && perf_en && (stall_exp != 32'hFFFF_FFFF)) begin
            stall_exp = stall_exp + 32'd1;
        end
        if (out_hs) begin
            check("out_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_pd = exp_q.pop_front();
                check("out_pd", 64'(o_pd), 64'(exp_pd));
            end
            check("done", 64'(done), 64'(rcvd == n - 1));
            if (done) done_cnt++;
            rcvd++;
            if (rcvd == n) active = 1'b0;
        end else begin
            check("done_quiet", 64'(done), 64'd0);
        end
        if (in_hs) begin
            check("in_limit", 64'(sent < n), 64'd1);
            exp_q.push_back(src_pd);
            sent++;
            src_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input bit m, input int nb, input int ip, input int op,
                               input bit perf, input int fl);
        mode       = m;
        n          = nb;
        in_prob    = ip;
        out_prob   = op;
        perf_en    = perf;
        force_left = fl;
        sent       = 0;
        rcvd       = 0;
        done_cnt   = 0;
        src_valid  = 1'b0;
        active     = 1'b0;
        stall_exp  = 32'd0;
        op_load    = 1'b1;
        flying     = m;
        beat_num   = 32'(nb - 1);
        step();
        op_load    = 1'b0;
        active     = 1'b1;
    endtask

    task automatic run_layer(input bit m, input int nb, input int ip, input int op,
                             input bit perf, input int fl, input int ign_at);
        int cyc;
        start_layer(m, nb, ip, op, perf, fl);
        cyc = 0;
        while (rcvd < n && cyc < 60 * nb + 50) begin
            if (cyc == ign_at) begin
                op_load  = 1'b1;
                flying   = ~m;
                beat_num = 32'd0;
            end
            step();
            op_load  = 1'b0;
            flying   = m;
            beat_num = 32'(nb - 1);
            cyc++;
        end
        check("beats_out", 64'(rcvd), 64'(n));
        check("beats_in", 64'(sent), 64'(n));
        check("done_count", 64'(done_cnt), 64'd1);
        check("stall_cnt", 64'(stall), 64'(stall_exp));
    endtask

    initial begin
        rstn     = 1'b0;
        op_load  = 1'b0;
        flying   = 1'b0;
        beat_num = 32'd0;
        perf_en  = 1'b0;
        m_valid  = 1'b0;
        m_pd     = '0;
        c_valid  = 1'b0;
        c_pd     = '0;
        o_ready  = 1'b0;
        mode     = 1'b0;
        active   = 1'b0;
        noise    = 1'b0;
        use_seq  = 1'b0;
        n        = 0;
        sent     = 0;
        rcvd     = 0;
        src_valid = 1'b0;
        src_pd   = '0;
        stall_exp = 32'd0;
        force_left = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_c_ready", 64'(c_ready), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_pd", 64'(o_pd), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rstn = 1'b1;

        // Basic MRDMA layer, sequential payloads, full throughput
        use_seq = 1'b1;
        run_layer(1'b0, 4, 100, 100, 1'b0, 0, -1);
        use_seq = 1'b0;

        // Flying mode while MRDMA keeps offering beats, then one idle cycle
        noise = 1'b1;
        run_layer(1'b1, 1, 100, 100, 1'b0, 0, -1);
        step();
        noise = 1'b0;

        // Output backpressure for 5 valid cycles
        run_layer(1'b0, 8, 100, 100, 1'b1, 5, -1);
        check("stall_five", 64'(stall), 64'd5);

        // Random soak, 1000 beats
        noise = 1'b1;
        run_layer(1'b1, 1000, 60, 60, 1'b1, 0, -1);
        noise = 1'b0;

        // Reset in the middle of a layer with the FIFO full
        start_layer(1'b0, 10, 100, 0, 1'b1, 0);
        for (int i = 0; i < 20 && exp_q.size() < 2; i++) step();
        check("fifo_fill", 64'(exp_q.size()), 64'd2);
        rstn    = 1'b0;
        m_valid = 1'b0;
        c_valid = 1'b0;
        o_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(o_valid), 64'd0);
        check("mid_rst_m_ready", 64'(m_ready), 64'd0);
        check("mid_rst_c_ready", 64'(c_ready), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        rstn      = 1'b1;
        exp_q.delete();
        src_valid = 1'b0;
        active    = 1'b0;
        stall_exp = 32'd0;
        run_layer(1'b0, 2, 100, 100, 1'b0, 0, -1);

        // Ignored op_load during RUN, then back-to-back layers
        run_layer(1'b1, 6, 80, 80, 1'b1, 0, 3);
        run_layer(1'b0, 3, 100, 100, 1'b0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
